snake_body_draw: RTL and testbench

SNAKE_BODY_DRAW -- requirements
Module: snake_body_draw

---
 rtl/snake_body_draw_pkg.sv | 24 ++
 rtl/snake_body_draw_if.sv | 18 +
 rtl/snake_body_draw_sprite_rom.sv | 53 +++++
 rtl/snake_body_draw.sv | 160 ++++++++++++++++
 tb/tb_snake_body_draw.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/snake_body_draw_pkg.sv
// Shared types and constants for the snake sprite renderer.
package snake_pkg;

  localparam int unsigned COORD_W = 11;

  localparam logic [3:0] DIR_UP    = 4'b1000;
  localparam logic [3:0] DIR_DOWN  = 4'b0100;
  localparam logic [3:0] DIR_LEFT  = 4'b0010;
  localparam logic [3:0] DIR_RIGHT = 4'b0001;

  localparam logic [11:0] TRANSPARENT = 12'hFFF;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } seg_t;

endpackage

// File: rtl/snake_body_draw_if.sv
// Sprite lookup bus: stage-1 hit registers in, raw texel out.
interface snake_body_draw_if #(
  parameter int unsigned TILE = 32
);
  import snake_pkg::*;

  localparam int unsigned OFF_W = $clog2(TILE);

  logic             head;
  logic [3:0]       dir;
  logic [OFF_W-1:0] ox;
  logic [OFF_W-1:0] oy;
  rgb12_t           texel;

  modport master (output head, dir, ox, oy, input texel);
  modport slave  (input head, dir, ox, oy, output texel);

endinterface

// File: rtl/snake_body_draw_sprite_rom.sv
// Head/body bitmaps with head orientation transform; purely combinational.
module snake_sprite_rom
  import snake_pkg::*;
#(
  parameter int unsigned TILE = 32
) (
  snake_body_draw_if.slave bus
);

  localparam int unsigned OFF_W = $clog2(TILE);
  localparam logic [OFF_W-1:0] EDGE = OFF_W'(TILE - 1);

  // Head: four transparent corners, row/col coded into the channels.
  function automatic rgb12_t head_texel(input logic [OFF_W-1:0] r, input logic [OFF_W-1:0] c);
    logic [5:0] r6;
    logic [5:0] c6;
    r6 = 6'(r);
    c6 = 6'(c);
    if ((r == '0 || r == EDGE) && (c == '0 || c == EDGE)) return TRANSPARENT;
    return {r6[3:0], c6[3:0], r6[5:4], c6[5:4]};
  endfunction

  // Body: transparent top-left texel, otherwise a row^col pattern.
  function automatic rgb12_t body_texel(input logic [OFF_W-1:0] r, input logic [OFF_W-1:0] c);
    logic [5:0] r6;
    logic [5:0] c6;
    r6 = 6'(r);
    c6 = 6'(c);
    if (r == '0 && c == '0) return TRANSPARENT;
    return {r6[3:0] ^ c6[3:0] ^ 4'hD, r6[3:0], c6[3:0]};
  endfunction

  logic [OFF_W-1:0] row_c;
  logic [OFF_W-1:0] col_c;

  always_comb begin
    row_c = bus.oy;
    col_c = bus.ox;
    if (bus.head) begin
      case (bus.dir)
        DIR_DOWN:  begin row_c = EDGE - bus.oy; col_c = bus.ox;        end
        DIR_LEFT:  begin row_c = bus.ox;        col_c = bus.oy;        end
        DIR_RIGHT: begin row_c = EDGE - bus.ox; col_c = EDGE - bus.oy; end
        default:   begin row_c = bus.oy;        col_c = bus.ox;        end
      endcase
    end
  end

  always_comb begin
    bus.texel = bus.head ? head_texel(row_c, col_c) : body_texel(row_c, col_c);
  end

endmodule

// File: rtl/snake_body_draw.sv
// Snake segment buffer plus two-stage pixel renderer (hit test, sprite lookup).
// Optional macro SNAKE_BODY_STRIPE_EN: odd body segments drawn at half brightness.
module snake_body_draw
  import snake_pkg::*;
#(
  parameter int unsigned TILE    = 32,
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned START_X = 0,
  parameter int unsigned START_Y = 0
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [10:0] pxl_x,
  input  logic [10:0] pxl_y,
  input  logic        step,
  input  logic        grow,
  input  logic [10:0] head_x,
  input  logic [10:0] head_y,
  input  logic [3:0]  direction,
  output logic [3:0]  Red_level,
  output logic [3:0]  Green_level,
  output logic [3:0]  Blue_level,
  output logic        Drawing,
  output logic [6:0]  length,
  output logic        full
);

  localparam int unsigned OFF_W = $clog2(TILE);
  localparam int unsigned IDX_W = $clog2(MAX_LEN);
  localparam int unsigned LEN_W = 7;
  localparam seg_t START_SEG = {COORD_W'(START_X), COORD_W'(START_Y)};

  seg_t             seg_q [MAX_LEN];
  logic [LEN_W-1:0] len_q, len_d;
  logic             grow_pend_q, grow_pend_d;
  logic             full_q;

  // Grow requests collapse into one pending flag consumed by the next step.
  always_comb begin
    len_d       = len_q;
    grow_pend_d = grow_pend_q;
    if (step) begin
      grow_pend_d = 1'b0;
      if ((grow || grow_pend_q) && len_q < LEN_W'(MAX_LEN)) len_d = len_q + LEN_W'(1);
    end else if (grow) begin
      grow_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int unsigned i = 0; i < MAX_LEN; i++) seg_q[i] <= START_SEG;
      len_q       <= LEN_W'(1);
      grow_pend_q <= 1'b0;
      full_q      <= 1'b0;
    end else begin
      if (step) begin
        seg_q[0] <= {head_x, head_y};
        for (int unsigned i = 1; i < MAX_LEN; i++) seg_q[i] <= seg_q[i-1];
      end
      len_q       <= len_d;
      grow_pend_q <= grow_pend_d;
      full_q      <= (len_d == LEN_W'(MAX_LEN));
    end
  end

  logic             hit_c;
  logic [IDX_W-1:0] idx_c;
  logic [OFF_W-1:0] ox_c, oy_c;

  // Walk from tail to head so the lowest matching index wins.
  always_comb begin
    hit_c = 1'b0;
    idx_c = '0;
    ox_c  = '0;
    oy_c  = '0;
    for (int i = int'(MAX_LEN) - 1; i >= 0; i--) begin
      if (LEN_W'(i) < len_q &&
          {1'b0, pxl_x} >= {1'b0, seg_q[i].x} &&
          {1'b0, pxl_x} <= {1'b0, seg_q[i].x} + 12'(TILE - 1) &&
          {1'b0, pxl_y} >= {1'b0, seg_q[i].y} &&
          {1'b0, pxl_y} <= {1'b0, seg_q[i].y} + 12'(TILE - 1)) begin
        hit_c = 1'b1;
        idx_c = IDX_W'(i);
        ox_c  = OFF_W'(pxl_x - seg_q[i].x);
        oy_c  = OFF_W'(pxl_y - seg_q[i].y);
      end
    end
  end

  logic             s1_valid_q, s1_hit_q;
  logic [IDX_W-1:0] s1_idx_q;
  logic [OFF_W-1:0] s1_ox_q, s1_oy_q;
  logic [3:0]       s1_dir_q;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      s1_valid_q <= 1'b0;
      s1_hit_q   <= 1'b0;
      s1_idx_q   <= '0;
      s1_ox_q    <= '0;
      s1_oy_q    <= '0;
      s1_dir_q   <= DIR_UP;
    end else begin
      s1_valid_q <= 1'b1;
      s1_hit_q   <= hit_c;
      s1_idx_q   <= idx_c;
      s1_ox_q    <= ox_c;
      s1_oy_q    <= oy_c;
      s1_dir_q   <= direction;
    end
  end

  snake_body_draw_if #(.TILE(TILE)) rom_bus ();

  assign rom_bus.head = (s1_idx_q == '0);
  assign rom_bus.dir  = s1_dir_q;
  assign rom_bus.ox   = s1_ox_q;
  assign rom_bus.oy   = s1_oy_q;

  snake_sprite_rom #(.TILE(TILE)) u_rom (.bus(rom_bus.slave));

  rgb12_t shade_c;
  logic   opaque_c;

  always_comb begin
    shade_c = rom_bus.texel;
`ifdef SNAKE_BODY_STRIPE_EN
    if (s1_idx_q[0]) begin
      shade_c.r = rom_bus.texel.r >> 1;
      shade_c.g = rom_bus.texel.g >> 1;
      shade_c.b = rom_bus.texel.b >> 1;
    end
`endif
  end

  assign opaque_c = s1_valid_q && s1_hit_q && (rom_bus.texel != TRANSPARENT);

  rgb12_t rgb_q;
  logic   drawing_q;

  // Colour holds across transparent or missed pixels.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      drawing_q <= 1'b0;
      rgb_q     <= 12'hFFF;
    end else begin
      drawing_q <= opaque_c;
      if (opaque_c) rgb_q <= shade_c;
    end
  end

  assign Red_level   = rgb_q.r;
  assign Green_level = rgb_q.g;
  assign Blue_level  = rgb_q.b;
  assign Drawing     = drawing_q;
  assign length      = len_q;
  assign full        = full_q;

endmodule

// File: tb/tb_snake_body_draw.sv
// Randomized bench for snake_body_draw against a behavioural pixel/segment model.
module tb_snake_body_draw;
  import snake_pkg::*;

  localparam int TILE  = 32;
  localparam int MAXL  = 4;
  localparam int SX    = 64;
  localparam int SY    = 64;
  localparam int OFF_W = $clog2(TILE);

`ifdef SNAKE_BODY_STRIPE_EN
  localparam int EXP_BODY3 = 'h633;
  localparam int EXP_BODY1 = 'h251;
`else
  localparam int EXP_BODY3 = 'hD66;
  localparam int EXP_BODY1 = 'h4A3;
`endif

  logic        clk = 1'b0;
  logic        resetN = 1'b1;
  logic [10:0] pxl_x = '0, pxl_y = '0, head_x = '0, head_y = '0;
  logic        step = 1'b0, grow = 1'b0;
  logic [3:0]  direction = 4'b1000;
  logic [3:0]  red, green, blue;
  logic        drawing, full;
  logic [6:0]  length;
  logic [11:0] rgb;
  assign rgb = {red, green, blue};

  always #5 clk = ~clk;

  snake_body_draw #(.TILE(TILE), .MAX_LEN(MAXL), .START_X(SX), .START_Y(SY)) dut (
    .clk(clk), .resetN(resetN), .pxl_x(pxl_x), .pxl_y(pxl_y), .step(step), .grow(grow),
    .head_x(head_x), .head_y(head_y), .direction(direction),
    .Red_level(red), .Green_level(green), .Blue_level(blue),
    .Drawing(drawing), .length(length), .full(full)
  );

  snake_body_draw_if #(.TILE(TILE)) rom_if ();
  snake_sprite_rom #(.TILE(TILE)) u_rom_chk (.bus(rom_if.slave));

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", nm, $time, act, exp);
    end
  endtask

  function automatic int head_tex(input int r, input int c);
    if ((r == 0 || r == TILE - 1) && (c == 0 || c == TILE - 1)) return 'hFFF;
    return ((r % 16) << 8) | ((c % 16) << 4) | (((r / 16) % 4) << 2) | ((c / 16) % 4);
  endfunction

  function automatic int body_tex(input int r, input int c);
    if (r == 0 && c == 0) return 'hFFF;
    return ((((r ^ c) % 16) ^ 13) << 8) | ((r % 16) << 4) | (c % 16);
  endfunction

  function automatic int texel_at(input int i, input int ox, input int oy, input logic [3:0] d);
    if (i != 0) return body_tex(oy, ox);
    case (d)
      4'b0100: return head_tex(TILE - 1 - oy, ox);
      4'b0010: return head_tex(ox, oy);
      4'b0001: return head_tex(TILE - 1 - ox, TILE - 1 - oy);
      default: return head_tex(oy, ox);
    endcase
  endfunction

  function automatic int shade(input int i, input int t);
`ifdef SNAKE_BODY_STRIPE_EN
    if (i % 2 == 1) return ((t >> 9) & 7) << 8 | ((t >> 5) & 7) << 4 | ((t >> 1) & 7);
`endif
    if (i < 0) return 0;
    return t;
  endfunction

  // Model state: segment list, length, pending grow, one pixel in flight.
  int mx [MAXL];
  int my [MAXL];
  int mlen = 1, mpend = 0;
  bit r1_v = 1'b0, r1_op = 1'b0;
  int r1_rgb = 0;
  int e_draw = 0, e_rgb = 'hFFF;

  function automatic void predict(input int px, input int py, input logic [3:0] d,
                                  output bit op, output int col);
    int t;
    op = 1'b0;
    col = 0;
    for (int i = 0; i < mlen; i++) begin
      if (px >= mx[i] && px < mx[i] + TILE && py >= my[i] && py < my[i] + TILE) begin
        t = texel_at(i, px - mx[i], py - my[i], d);
        op = (t != 'hFFF);
        col = shade(i, t);
        return;
      end
    end
  endfunction

  always @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < MAXL; i++) begin mx[i] = SX; my[i] = SY; end
      mlen = 1; mpend = 0; r1_v = 1'b0; e_draw = 0; e_rgb = 'hFFF;
    end else begin
      e_draw = (r1_v && r1_op) ? 1 : 0;
      if (e_draw == 1) e_rgb = r1_rgb;
      predict(int'(pxl_x), int'(pxl_y), direction, r1_op, r1_rgb);
      r1_v = 1'b1;
      if (step) begin
        for (int i = MAXL - 1; i > 0; i--) begin mx[i] = mx[i-1]; my[i] = my[i-1]; end
        mx[0] = int'(head_x); my[0] = int'(head_y);
        if ((grow || mpend != 0) && mlen < MAXL) mlen++;
        mpend = 0;
      end else if (grow) begin
        mpend = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("drawing", int'(drawing), e_draw);
      check("rgb", int'(rgb), e_rgb);
      check("length", int'(length), mlen);
      check("full", int'(full), (mlen == MAXL) ? 1 : 0);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_pix(input int x, input int y, input logic [3:0] d);
    pxl_x = 11'(x); pxl_y = 11'(y); direction = d;
  endtask

  task automatic do_step(input int hx, input int hy, input bit g);
    step = 1'b1; grow = g; head_x = 11'(hx); head_y = 11'(hy);
    tick(1);
    step = 1'b0; grow = 1'b0;
  endtask

  initial begin
    // Model bitmap pins and standalone ROM lookups.
    check("model_head_16_6", head_tex(16, 6), 'h064);
    check("model_body_10_3", body_tex(10, 3), 'h4A3);
    for (int n = 0; n < 40; n++) begin
      rom_if.head = 1'($urandom_range(1));
      rom_if.dir  = 4'($urandom_range(15));
      rom_if.ox   = OFF_W'($urandom_range(TILE - 1));
      rom_if.oy   = OFF_W'($urandom_range(TILE - 1));
      #1;
      check("rom_texel", int'(rom_if.texel),
            texel_at(rom_if.head ? 0 : 1, int'(rom_if.ox), int'(rom_if.oy), rom_if.dir));
    end

    @(negedge clk); #2 resetN = 1'b0; chk_en = 1'b1;
    tick(2);
    check("rst_rgb", int'(rgb), 'hFFF);
    check("rst_drawing", int'(drawing), 0);
    check("rst_length", int'(length), 1);
    check("rst_full", int'(full), 0);

    set_pix(70, 80, 4'b1000);
    #2 resetN = 1'b1;
    tick(2);
    check("head_up_draw", int'(drawing), 1);
    check("head_up_rgb", int'(rgb), 'h064);
    check("head_up_len", int'(length), 1);

    set_pix(67, 84, 4'b0010); tick(2);
    check("head_left_rgb", int'(rgb), 'h341);
    set_pix(67, 84, 4'b0001); tick(2);
    check("head_right_rgb", int'(rgb), 'hCB4);
    set_pix(64, 64, 4'b1000); tick(2);
    check("corner_draw", int'(drawing), 0);
    check("corner_rgb_hold", int'(rgb), 'hCB4);

    do_step(96, 64, 1'b1); do_step(128, 64, 1'b1); do_step(160, 64, 1'b1);
    check("grow_len4", int'(length), 4);
    check("grow_full", int'(full), 1);
    set_pix(70, 70, 4'b1000); tick(2);
    check("seg3_draw", int'(drawing), 1);
    check("seg3_rgb", int'(rgb), EXP_BODY3);

    do_step(192, 64, 1'b1); tick(2);
    check("full_len", int'(length), 4);
    check("full_flag", int'(full), 1);
    check("tail_dropped", int'(drawing), 0);
    check("tail_rgb_hold", int'(rgb), EXP_BODY3);

    // Pending grow must not survive reset.
    grow = 1'b1; tick(1); grow = 1'b0;
    #2 resetN = 1'b0; tick(1); #2 resetN = 1'b1; tick(1);
    do_step(200, 64, 1'b0);
    check("rst_drops_pend", int'(length), 1);

    grow = 1'b1; tick(1); grow = 1'b0; tick(1);
    check("grow_alone_wait", int'(length), 1);
    do_step(232, 64, 1'b0);
    check("grow_on_step", int'(length), 2);
    set_pix(203, 74, 4'b1000); tick(2);
    check("seg1_draw", int'(drawing), 1);
    check("seg1_rgb", int'(rgb), EXP_BODY1);

    grow = 1'b1; tick(1); grow = 1'b1; tick(1); grow = 1'b0;
    do_step(264, 64, 1'b0);
    check("two_grows_one", int'(length), 3);
    do_step(296, 64, 1'b0);
    check("pend_cleared", int'(length), 3);

    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      step = ($urandom_range(3) == 0);
      grow = ($urandom_range(4) == 0);
      if ($urandom_range(7) == 0) begin
        head_x = 11'(2000 + $urandom_range(47)); head_y = 11'(2000 + $urandom_range(47));
        pxl_x = 11'($urandom_range(40)); pxl_y = 11'($urandom_range(40));
      end else begin
        head_x = 11'($urandom_range(380)); head_y = 11'($urandom_range(380));
        pxl_x = 11'($urandom_range(420)); pxl_y = 11'($urandom_range(420));
      end
      if ($urandom_range(9) == 0) begin
        pxl_x = 11'(2000 + $urandom_range(47)); pxl_y = 11'(2000 + $urandom_range(47));
      end
      direction = ($urandom_range(3) == 0) ? 4'($urandom_range(15)) : 4'(1 << $urandom_range(3));
      if (!resetN) begin
        #2 resetN = 1'b1;
      end else if ($urandom_range(299) == 0) begin
        #2 resetN = 1'b0;
      end
    end

    @(negedge clk);
    step = 1'b0; grow = 1'b0;
    #2 resetN = 1'b1;
    tick(3);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
